mux_arb_rr: RTL and testbench
=============================

MUX_ARB_RR -- requirements
Module: mux_arb_rr

Interface
REQ-001 Parameters SHALL be:
- N_CH, default 4: number of input channels, >= 2.
- W, default 4: data width per channel, >= 1.
- SEL_W, default $clog2(N_CH): channel-index width.

REQ-002 Ports SHALL be:
- clk  in  1  clock; all state updates on rising edge.
- rst_n  in  1  reset; synchronous, active-low.
- rr_en  in  1  arbitration mode: 1 round-robin, 0 fixed priority (lowest index wins).
- in_valid  in  N_CH  per-channel request.
- in_data  in  N_CH*W  channel i occupies bits [i*W +: W].
- in_ready  out  N_CH  per-channel accept; one-hot or zero.
- out_valid  out  1  output holds a beat.
- out_data  out  W  selected data.
- out_sel  out  SEL_W  index of the channel that supplied out_data.
- out_ready  in  1  downstream accept.

Function
REQ-003 Transfers SHALL occur on a rising edge only:
- input i: when in_valid[i] && in_ready[i];
- output: when out_valid && out_ready.
REQ-004 The output stage SHALL be able to load (load_en) when !out_valid || out_ready.
REQ-005 When load_en is 1 and any in_valid is 1, exactly one in_ready bit SHALL be 1, for the granted channel g; otherwise in_ready SHALL be all zero.
REQ-006 in_ready SHALL be combinational from in_valid, rr_en, out_valid, out_ready and the priority pointer; it SHALL NOT depend on in_data.
REQ-007 Grant selection:
- rr_en=1: g is the first valid index found searching upward from the pointer, wrapping N_CH-1 -> 0.
- rr_en=0: g is the lowest valid index.
REQ-008 On a grant, the next edge SHALL load out_data=in_data[g], out_sel=g, out_valid=1 (latency 1 cycle).
REQ-009 On a grant, the pointer SHALL become (g+1) mod N_CH in both modes; with no grant the pointer SHALL hold.
REQ-010 If out_valid && out_ready with no grant, out_valid SHALL go to 0; out_data and out_sel SHALL hold.
REQ-011 If out_valid && !out_ready, out_valid, out_data and out_sel SHALL hold unchanged, and in_ready SHALL be all zero (backpressure).
REQ-012 Simultaneous output drain and new grant in the same cycle SHALL sustain one beat per cycle with no bubble.
REQ-013 A change of rr_en SHALL affect the grant in the same cycle and SHALL NOT reset the pointer.
REQ-014 in_data containing X/Z on non-granted channels SHALL NOT affect out_data.
REQ-015 A granted channel carrying X data SHALL propagate X to out_data unchanged.

Reset
REQ-016 While rst_n=0 at a rising edge, out_valid, out_data, out_sel and the pointer SHALL all become 0.
REQ-017 While rst_n=0, in_ready SHALL be all zero.
REQ-018 Reset asserted mid-transfer SHALL discard the held beat; no input is accepted in that cycle.
REQ-019 The first grant after rst_n rises SHALL use pointer 0.

Structure
REQ-020 A shared package mux_arb_pkg SHALL hold:
- default parameter constants N_CH_DEF=4 and W_DEF=4;
- a function that computes the wrapped pointer increment.
REQ-021 Grant logic SHALL be a combinational sub-module rr_prio_enc(N_CH):
- inputs: req, ptr, rr_en;
- outputs: one-hot grant and index.
REQ-022 All sequential state SHALL be in the top module: output register and pointer.

Verification (N_CH=4, W=4)
REQ-023 The bench SHALL cover these directed scenarios:
- Single source: in_valid=4'b0100, in_data ch2='hc, out_ready=1 -> in_ready=4'b0100; next cycle out_valid=1, out_data='hc, out_sel=2.
- Round-robin fairness: rr_en=1, all valid, data {'ha,'hb,'hc,'hd}, out_ready=1 for 8 cycles -> out_sel sequence 0,1,2,3,0,1,2,3 with data matching, one beat per cycle.
- Fixed priority: rr_en=0, all valid for 4 cycles -> out_sel=0 every cycle; then in_valid=4'b1010 -> out_sel=1.
- Backpressure: beat 'h7 held with out_ready=0 for 3 cycles -> out_data='h7 stable, in_ready=0; release -> next beat loads on the same edge.
- Wrap and X isolation: pointer=3, in_valid=4'b1001, ch1 data='x -> grant ch3, then ch0; out_data is never X.
- Reset mid-operation: out_valid=1 holding 'hb, rst_n=0 for 1 cycle -> out_valid=0, out_data=0, out_sel=0; next grant searches from ch0.

Source files
------------

// File: rtl/mux_arb_pkg.sv
// Shared constants and helpers for the round-robin / fixed-priority N:1 mux arbiter.
package mux_arb_pkg;

   localparam int unsigned N_CH_DEF = 4;
   localparam int unsigned W_DEF    = 4;

   typedef enum logic {
      ARB_FIXED = 1'b0,
      ARB_RR    = 1'b1
   } arb_mode_e;

   // Next priority pointer: one past the granted channel, wrapping to 0.
   function automatic int unsigned ptr_wrap_inc(input int unsigned idx, input int unsigned n);
      int unsigned nxt;
      nxt = idx + 1;
      if (nxt >= n) nxt = 0;
      return nxt;
   endfunction

endpackage

// File: rtl/rr_prio_enc.sv
// Combinational grant encoder: rotating search from ptr (round-robin) or from 0 (fixed).
module rr_prio_enc
   import mux_arb_pkg::*;
#(
   parameter int unsigned N_CH  = N_CH_DEF,
   parameter int unsigned SEL_W = $clog2(N_CH)
) (
   input  logic [N_CH-1:0]  req,
   input  logic [SEL_W-1:0] ptr,
   input  logic             rr_en,
   output logic [N_CH-1:0]  grant,
   output logic [SEL_W-1:0] idx
);

   arb_mode_e  mode;
   logic [SEL_W:0] base;
   logic [SEL_W:0] cand;
   logic           found;

   assign mode = arb_mode_e'(rr_en);

   // Extra bit on cand lets ptr+k exceed N_CH-1 before the wrap subtract.
   always_comb begin
      grant = '0;
      idx   = '0;
      found = 1'b0;
      cand  = '0;
      base  = (mode == ARB_RR) ? {1'b0, ptr} : '0;
      for (int unsigned k = 0; k < N_CH; k++) begin
         cand = base + (SEL_W+1)'(k);
         if (cand >= (SEL_W+1)'(N_CH)) cand = cand - (SEL_W+1)'(N_CH);
         if (!found && req[cand[SEL_W-1:0]]) begin
            found                  = 1'b1;
            grant[cand[SEL_W-1:0]] = 1'b1;
            idx                    = cand[SEL_W-1:0];
         end
      end
   end

endmodule

// File: rtl/mux_arb_rr.sv
// N_CH:1 arbitrated mux with a single registered output stage and valid/ready handshakes.
module mux_arb_rr
   import mux_arb_pkg::*;
#(
   parameter int unsigned N_CH  = N_CH_DEF,
   parameter int unsigned W     = W_DEF,
   parameter int unsigned SEL_W = $clog2(N_CH)
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              rr_en,
   input  logic [N_CH-1:0]   in_valid,
   input  logic [N_CH*W-1:0] in_data,
   output logic [N_CH-1:0]   in_ready,
   output logic              out_valid,
   output logic [W-1:0]      out_data,
   output logic [SEL_W-1:0]  out_sel,
   input  logic              out_ready
);

   logic [SEL_W-1:0] ptr;
   logic [N_CH-1:0]  grant;
   logic [SEL_W-1:0] grant_idx;
   logic             load_en;
   logic             take;
   logic [W-1:0]     sel_data;

   rr_prio_enc #(
      .N_CH  (N_CH),
      .SEL_W (SEL_W)
   ) u_enc (
      .req   (in_valid),
      .ptr   (ptr),
      .rr_en (rr_en),
      .grant (grant),
      .idx   (grant_idx)
   );

   assign load_en  = !out_valid || out_ready;
   assign in_ready = (rst_n && load_en) ? grant : '0;
   assign take     = |in_ready;
   // Only the granted slice is read, so X on other channels cannot reach out_data.
   assign sel_data = in_data[grant_idx*W +: W];

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         out_valid <= 1'b0;
         out_data  <= '0;
         out_sel   <= '0;
         ptr       <= '0;
      end else if (take) begin
         out_valid <= 1'b1;
         out_data  <= sel_data;
         out_sel   <= grant_idx;
         ptr       <= SEL_W'(ptr_wrap_inc(32'(grant_idx), N_CH));
      end else if (load_en) begin
         out_valid <= 1'b0;
      end
   end

endmodule

// File: tb/tb_mux_arb_rr.sv
// Directed self-checking bench for mux_arb_rr with N_CH=4, W=4.
module tb_mux_arb_rr;

   logic        clk;
   logic        rst_n;
   logic        rr_en;
   logic [3:0]  in_valid;
   logic [15:0] in_data;
   logic [3:0]  in_ready;
   logic        out_valid;
   logic [3:0]  out_data;
   logic [1:0]  out_sel;
   logic        out_ready;

   int tests = 0;
   int fails = 0;

   mux_arb_rr #(
      .N_CH  (4),
      .W     (4),
      .SEL_W (2)
   ) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .rr_en     (rr_en),
      .in_valid  (in_valid),
      .in_data   (in_data),
      .in_ready  (in_ready),
      .out_valid (out_valid),
      .out_data  (out_data),
      .out_sel   (out_sel),
      .out_ready (out_ready)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp)
      else begin
         fails++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic chk_out(input string tag, input logic v, input logic [3:0] d, input logic [1:0] s);
      chk({tag, ".valid"}, 32'(out_valid), 32'(v));
      chk({tag, ".data"},  32'(out_data),  32'(d));
      chk({tag, ".sel"},   32'(out_sel),   32'(s));
   endtask

   initial begin
      logic [3:0] exp_rdy;

      rst_n     = 1'b0;
      rr_en     = 1'b1;
      in_valid  = 4'b1111;
      in_data   = 16'h0000;
      out_ready = 1'b0;
      tick();
      tick();
      chk_out("reset", 1'b0, 4'h0, 2'd0);
      chk("reset.in_ready", 32'(in_ready), 32'h0);

      // Single source on ch2
      rst_n     = 1'b1;
      in_valid  = 4'b0100;
      in_data   = 16'h0c00;
      out_ready = 1'b1;
      #1;
      chk("single.in_ready", 32'(in_ready), 32'h4);
      tick();
      chk_out("single.out", 1'b1, 4'hc, 2'd2);
      in_valid = 4'b0000;
      tick();
      chk_out("single.drain", 1'b0, 4'hc, 2'd2);

      // Reset to bring pointer back to 0, then round-robin over all four
      rst_n = 1'b0;
      tick();
      rst_n    = 1'b1;
      rr_en    = 1'b1;
      in_valid = 4'b1111;
      in_data  = 16'hdcba;
      for (int i = 0; i < 8; i++) begin
         exp_rdy = 4'b0001 << (i % 4);
         #1;
         chk("rr.in_ready", 32'(in_ready), 32'(exp_rdy));
         tick();
         chk_out("rr.out", 1'b1, 4'(4'ha + (i % 4)), 2'(i % 4));
      end

      // Fixed priority
      rr_en = 1'b0;
      for (int i = 0; i < 4; i++) begin
         #1;
         chk("fixed.in_ready", 32'(in_ready), 32'h1);
         tick();
         chk_out("fixed.out", 1'b1, 4'ha, 2'd0);
      end
      in_valid = 4'b1010;
      #1;
      chk("fixed1010.in_ready", 32'(in_ready), 32'h2);
      tick();
      chk_out("fixed1010.out", 1'b1, 4'hb, 2'd1);

      // Backpressure holding beat 7
      in_valid = 4'b0001;
      in_data  = 16'hdcb7;
      tick();
      chk_out("bp.load", 1'b1, 4'h7, 2'd0);
      in_valid  = 4'b0010;
      out_ready = 1'b0;
      for (int i = 0; i < 3; i++) begin
         #1;
         chk("bp.in_ready", 32'(in_ready), 32'h0);
         tick();
         chk_out("bp.hold", 1'b1, 4'h7, 2'd0);
      end
      out_ready = 1'b1;
      #1;
      chk("bp.release.in_ready", 32'(in_ready), 32'h2);
      tick();
      chk_out("bp.next", 1'b1, 4'hb, 2'd1);

      // Pointer now 2; grant ch2 in RR mode to move it to 3
      rr_en    = 1'b1;
      in_valid = 4'b0100;
      in_data  = 16'h5690;
      tick();
      chk_out("wrap.setup", 1'b1, 4'h6, 2'd2);

      // Wrap with X on a non-granted channel
      in_valid = 4'b1001;
      in_data  = {4'h5, 4'h6, 4'bxxxx, 4'h9};
      #1;
      chk("wrap.in_ready3", 32'(in_ready), 32'h8);
      tick();
      chk_out("wrap.ch3", 1'b1, 4'h5, 2'd3);
      chk("wrap.ch3.noX", 32'($isunknown(out_data)), 32'h0);
      #1;
      chk("wrap.in_ready0", 32'(in_ready), 32'h1);
      tick();
      chk_out("wrap.ch0", 1'b1, 4'h9, 2'd0);
      chk("wrap.ch0.noX", 32'($isunknown(out_data)), 32'h0);

      // Granted X channel propagates X
      in_valid = 4'b0010;
      tick();
      chk_out("xprop", 1'b1, 4'bxxxx, 2'd1);

      // Reset mid-operation (pointer is 2 here)
      in_valid = 4'b0010;
      in_data  = 16'h00b0;
      tick();
      chk_out("rstmid.hold", 1'b1, 4'hb, 2'd1);
      out_ready = 1'b0;
      in_valid  = 4'b1111;
      in_data   = 16'hdcba;
      rst_n     = 1'b0;
      #1;
      chk("rstmid.in_ready", 32'(in_ready), 32'h0);
      tick();
      chk_out("rstmid.cleared", 1'b0, 4'h0, 2'd0);
      rst_n     = 1'b1;
      out_ready = 1'b1;
      #1;
      chk("rstmid.first.in_ready", 32'(in_ready), 32'h1);
      tick();
      chk_out("rstmid.first", 1'b1, 4'ha, 2'd0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
